pc_gen: RTL and testbench

Parametrised fetch program-counter generator for the in-order pipeline, successor to the single-width PC register. It produces the fetch address and chip enable for instruction fetch, and arbitrates three redirect sources: EX correction, ID branch and predictor. Redirects arriving while fetch is stalled are buffered rather than dropped. An optional return-address stack predicts `ret` targets.

---
 rtl/pc_gen_if.sv | 33 +++
 rtl/pc_gen.sv | 148 ++++++++++++++
 tb/tb_pc_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-PC generator bundle.
// master drives stall/redirect/predecode, slave owns pc/ce/pending.
interface pc_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int STALL_W = 6
);
   logic [STALL_W-1:0] stall;
   logic               ex_redirect_i;
   logic [ADDR_W-1:0]  ex_target_i;
   logic               branch_flag_i;
   logic [ADDR_W-1:0]  branch_target_address_i;
   logic               pdt_taken_i;
   logic [ADDR_W-1:0]  pdt_target_i;
   logic               call_i;
   logic               ret_i;
   logic [ADDR_W-1:0]  pc;
   logic               ce;
   logic               redirect_pending_o;

   modport master (
      output stall, ex_redirect_i, ex_target_i,
      output branch_flag_i, branch_target_address_i,
      output pdt_taken_i, pdt_target_i, call_i, ret_i,
      input  pc, ce, redirect_pending_o
   );

   modport slave (
      input  stall, ex_redirect_i, ex_target_i,
      input  branch_flag_i, branch_target_address_i,
      input  pdt_taken_i, pdt_target_i, call_i, ret_i,
      output pc, ce, redirect_pending_o
   );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with buffered redirects.
// Optional return-address stack enabled by PC_RAS_EN.
module pc_gen #(
   parameter int               ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
   parameter int               STALL_W     = 6,
   parameter int               FETCH_BYTES = 4,
   parameter int               RAS_DEPTH   = 4
) (
   input logic       clk,
   input logic       rst,
   pc_gen_if.slave   bus
);
   typedef enum logic [1:0] {S_OFF, S_BOOT, S_RUN, S_HOLD} state_t;

   localparam logic [ADDR_W-1:0] INC  = ADDR_W'(FETCH_BYTES);
   localparam logic [ADDR_W-1:0] MASK = ~(INC - ADDR_W'(1));

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d, seq_pc;
   logic               pend_v_q, pend_v_d;
   logic               pend_ex_q, pend_ex_d;
   logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d;
   logic               ras_push, ras_pop, ras_clr;
   logic               ras_hit;
   logic [ADDR_W-1:0]  ras_top;

   assign seq_pc = pc_q + INC;

`ifdef PC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]     sp_q, sp_dec, sp_inc;
   logic [CW-1:0]     cnt_q;
   logic              unused_ras;

   assign sp_dec  = (sp_q == '0) ? PW'(RAS_DEPTH - 1) : sp_q - PW'(1);
   assign sp_inc  = (sp_q == PW'(RAS_DEPTH - 1)) ? '0 : sp_q + PW'(1);
   assign ras_top = ras_q[sp_dec];
   assign ras_hit = (cnt_q != '0);
   assign unused_ras = ^bus.stall;

   // Stack pointer and occupancy; circular so overflow drops the oldest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else if (ras_clr) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else if (ras_pop && !ras_push) begin
         sp_q  <= sp_dec;
         cnt_q <= cnt_q - CW'(1);
      end else if (ras_push && !ras_pop) begin
         sp_q  <= sp_inc;
         if (cnt_q != CW'(RAS_DEPTH))
            cnt_q <= cnt_q + CW'(1);
      end
   end

   // Stack storage; pop+push rewrites the current top in place.
   always_ff @(posedge clk) begin
      if (ras_push && !ras_clr && !rst)
         ras_q[ras_pop ? sp_dec : sp_q] <= seq_pc;
   end
`else
   logic unused_ras;

   assign ras_hit    = 1'b0;
   assign ras_top    = '0;
   assign unused_ras = ^{bus.stall, bus.call_i, bus.ret_i,
                         ras_push, ras_pop, ras_clr, ras_top};
`endif

   // State register and fetch PC / pending redirect registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_OFF;
         pc_q       <= RESET_VEC;
         pend_v_q   <= 1'b0;
         pend_ex_q  <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_v_q   <= pend_v_d;
         pend_ex_q  <= pend_ex_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   // Next state, redirect arbitration and pending capture.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_v_d   = pend_v_q;
      pend_ex_d  = pend_ex_q;
      pend_tgt_d = pend_tgt_q;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      ras_clr    = 1'b0;
      unique case (state_q)
         S_OFF: state_d = S_BOOT;
         default: begin
            if (bus.stall[0]) begin
               state_d = S_HOLD;
               if (bus.ex_redirect_i) begin
                  pend_v_d   = 1'b1;
                  pend_ex_d  = 1'b1;
                  pend_tgt_d = bus.ex_target_i & MASK;
                  ras_clr    = 1'b1;
               end else if (bus.branch_flag_i &&
                            !(pend_v_q && pend_ex_q)) begin
                  pend_v_d   = 1'b1;
                  pend_ex_d  = 1'b0;
                  pend_tgt_d = bus.branch_target_address_i & MASK;
               end
            end else begin
               state_d  = S_RUN;
               ras_push = bus.call_i;
               if (bus.ex_redirect_i) begin
                  pc_d     = bus.ex_target_i & MASK;
                  pend_v_d = 1'b0;
                  ras_clr  = 1'b1;
               end else if (pend_v_q) begin
                  pc_d     = pend_tgt_q;
                  pend_v_d = 1'b0;
               end else if (bus.branch_flag_i) begin
                  pc_d = bus.branch_target_address_i & MASK;
               end else if (bus.ret_i && ras_hit) begin
                  pc_d    = ras_top;
                  ras_pop = 1'b1;
               end else if (bus.pdt_taken_i) begin
                  pc_d = bus.pdt_target_i & MASK;
               end else begin
                  pc_d = seq_pc;
               end
            end
         end
      endcase
   end

   assign bus.pc                 = pc_q;
   assign bus.ce                 = (state_q != S_OFF);
   assign bus.redirect_pending_o = pend_v_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen.
// RAS section only runs when PC_RAS_EN is defined.
module tb_pc_gen;
   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        ce;
      logic        pend;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

   pc_gen #(
      .ADDR_W(32), .RESET_VEC(32'h0), .STALL_W(6),
      .FETCH_BYTES(4), .RAS_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic drv(input logic s0, input logic ex,
                      input logic [31:0] ext, input logic br,
                      input logic [31:0] brt, input logic pdt,
                      input logic [31:0] pdtt, input logic call,
                      input logic ret);
      bus.stall                   = {5'b0, s0};
      bus.ex_redirect_i           = ex;
      bus.ex_target_i             = ext;
      bus.branch_flag_i           = br;
      bus.branch_target_address_i = brt;
      bus.pdt_taken_i             = pdt;
      bus.pdt_target_i            = pdtt;
      bus.call_i                  = call;
      bus.ret_i                   = ret;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic expect_push(input string tag, input logic [31:0] p,
                              input logic c, input logic pd);
      exp_t e;
      e.tag = tag; e.pc = p; e.ce = c; e.pend = pd;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      e = sb.pop_front();
      checks++;
      assert (bus.pc === e.pc) else begin
         failures++;
         $error("FAIL %s.pc observed=%h expected=%h", e.tag, bus.pc, e.pc);
      end
      checks++;
      assert (bus.ce === e.ce) else begin
         failures++;
         $error("FAIL %s.ce observed=%b expected=%b", e.tag, bus.ce, e.ce);
      end
      checks++;
      assert (bus.redirect_pending_o === e.pend) else begin
         failures++;
         $error("FAIL %s.pend observed=%b expected=%b", e.tag,
                bus.redirect_pending_o, e.pend);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] p,
                       input logic c, input logic pd);
      expect_push(tag, p, c, pd);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      idle();
      #2 rst = 1'b1;
      #1;
      expect_push("rst_async", 32'h0, 0, 0);
      compare();
      @(posedge clk);
      #1;
      expect_push("rst_held", 32'h0, 0, 0);
      compare();
      #2 rst = 1'b0;

      step("boot",  32'h0, 1, 0);
      step("seq4",  32'h4, 1, 0);
      step("seq8",  32'h8, 1, 0);
      step("seq12", 32'hC, 1, 0);

      drv(1, 0, 0, 1, 32'h103, 0, 0, 0, 0);
      step("hold_cap", 32'hC, 1, 1);
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("hold2", 32'hC, 1, 1);
      step("hold3", 32'hC, 1, 1);
      idle();
      step("release", 32'h100, 1, 0);
      step("after_rel", 32'h104, 1, 0);

      drv(0, 1, 32'h200, 1, 32'h300, 1, 32'h400, 0, 0);
      step("prio_ex", 32'h200, 1, 0);
      drv(1, 0, 0, 1, 32'h300, 0, 0, 0, 0);
      step("cap_id", 32'h200, 1, 1);
      drv(1, 1, 32'h500, 0, 0, 0, 0, 0, 0);
      step("ex_over_id", 32'h200, 1, 1);
      drv(0, 0, 0, 1, 32'h600, 0, 0, 0, 0);
      step("pend_ex_win", 32'h500, 1, 0);
      idle();
      step("seq_504", 32'h504, 1, 0);

      drv(1, 1, 32'h700, 0, 0, 0, 0, 0, 0);
      step("cap_ex", 32'h504, 1, 1);
      drv(1, 0, 0, 1, 32'h800, 0, 0, 0, 0);
      step("id_no_over", 32'h504, 1, 1);
      idle();
      step("rel_ex", 32'h700, 1, 0);

      drv(1, 0, 0, 0, 0, 1, 32'h900, 0, 0);
      step("hold_pdt", 32'h700, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h7F3, 0, 0);
      step("pdt_align", 32'h7F0, 1, 0);

      drv(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
      step("to_top", 32'hFFFF_FFFC, 1, 0);
      idle();
      step("wrap", 32'h0, 1, 0);
      step("wrap_seq", 32'h4, 1, 0);

      drv(0, 0, 0, 0, 0, 1, 32'h80, 0, 1);
      step("ret_empty", 32'h80, 1, 0);

      drv(1, 0, 0, 1, 32'h300, 0, 0, 0, 0);
      step("pre_rst", 32'h80, 1, 1);
      #2 rst = 1'b1;
      #1;
      expect_push("rst_hold", 32'h0, 0, 0);
      compare();
      #1 rst = 1'b0;
      idle();
      step("reboot", 32'h0, 1, 0);
      step("reboot4", 32'h4, 1, 0);

`ifdef PC_RAS_EN
      drv(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
      step("to40", 32'h40, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h80, 1, 0);
      step("call40", 32'h80, 1, 0);
      drv(0, 0, 0, 1, 32'h90, 0, 0, 0, 0);
      step("to90", 32'h90, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'hA0, 0, 1);
      step("ret90", 32'h44, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h100, 1, 0);
      step("c1", 32'h100, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h200, 1, 0);
      step("c2", 32'h200, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h300, 1, 0);
      step("c3", 32'h300, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h400, 1, 0);
      step("c4", 32'h400, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h500, 1, 0);
      step("c5", 32'h500, 1, 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step("r1", 32'h404, 1, 0);
      step("r2", 32'h304, 1, 0);
      step("r3", 32'h204, 1, 0);
      step("r4", 32'h104, 1, 0);
      drv(0, 0, 0, 0, 0, 1, 32'h900, 0, 1);
      step("r5_under", 32'h900, 1, 0);
`endif

      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
